fpu_sched: RTL

FPU_SCHED -- requirements
Module: fpu_sched

---
 rtl/fpu_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/fpu_sched.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the fpu scheduler: opcode enum and datapath widths.
package fpu_pkg;

  localparam int unsigned FP_WIDTH   = 16;
  localparam int unsigned FLAG_WIDTH = 3;
  localparam int unsigned OP_WIDTH   = 2;

  typedef enum logic [OP_WIDTH-1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    DIV = 2'd3
  } fpu_op_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after 'pointer'.
// Ports:
//   req     - request vector
//   pointer - index of the last granted requester; search starts at pointer+1
//   grant   - one-hot (or zero) grant, purely combinational
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] pointer,
  output logic [N-1:0]         grant
);

  localparam int unsigned PW = $clog2(N);

  int unsigned idx;
  logic        found;

  // Walk the requesters once, starting just past the pointer, wrapping modulo N.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(pointer) + k) % N;
      if (!found && req[PW'(idx)]) begin
        grant[PW'(idx)] = 1'b1;
        found           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_sched.sv
// Shares one fixed-latency fpu among NUM_REQ requesters.
// Round-robin issue, per-requester in-flight limit MAX_OUT, and an unstalled
// tag pipe that routes each result back PIPELINE_DEPTH cycles after issue.
// Ports:
//   clk, reset               - clock, synchronous active-high reset
//   req_valid/req_ready      - per-requester offer / accept (ready is combinational)
//   req_opA/req_opB/req_op   - flattened per-requester operands and opcode
//   fpu_opA/fpu_opB/fpu_op   - issue to the shared fpu (zero when idle)
//   fpu_result, fpu_*flow, fpu_inexact - fpu outputs, aligned with the response
//   rsp_valid/rsp_id/rsp_result/rsp_flags - returned result (zero when not valid)
//   busy                     - any operation in flight
// Build option: define FPU_SCHED_FLAGS_EN to forward fpu status flags on rsp_flags.
module fpu_sched
  import fpu_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned PIPELINE_DEPTH = 3,
  parameter int unsigned MAX_OUT        = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*FP_WIDTH-1:0]   req_opA,
  input  logic [NUM_REQ*FP_WIDTH-1:0]   req_opB,
  input  logic [NUM_REQ*OP_WIDTH-1:0]   req_op,
  output logic [FP_WIDTH-1:0]           fpu_opA,
  output logic [FP_WIDTH-1:0]           fpu_opB,
  output logic [OP_WIDTH-1:0]           fpu_op,
  input  logic [FP_WIDTH-1:0]           fpu_result,
  input  logic                          fpu_overflow,
  input  logic                          fpu_underflow,
  input  logic                          fpu_inexact,
  output logic                          rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [FP_WIDTH-1:0]           rsp_result,
  output logic [FLAG_WIDTH-1:0]         rsp_flags,
  output logic                          busy
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(MAX_OUT + 1);

  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  arb_grant;
  logic [NUM_REQ-1:0]  grant;
  logic [NUM_REQ-1:0]  rsp_dec;
  logic                gnt_any;
  logic [IW-1:0]       gnt_idx;
  logic [IW-1:0]       last_grant;
  logic [CW-1:0]       out_cnt [NUM_REQ];
  logic [PIPELINE_DEPTH-1:0] tag_valid;
  logic [IW-1:0]       tag_id [PIPELINE_DEPTH];

  // Response-cycle decrement counts toward eligibility so a full requester
  // can be re-granted in the very cycle its oldest result returns.
  always_comb begin
    eligible = '0;
    rsp_dec  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_dec[i]  = tag_valid[PIPELINE_DEPTH-1] && (tag_id[PIPELINE_DEPTH-1] == IW'(i));
      eligible[i] = req_valid[i] && ((out_cnt[i] < CW'(MAX_OUT)) || rsp_dec[i]);
    end
  end

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (eligible),
    .pointer (last_grant),
    .grant   (arb_grant)
  );

  assign grant     = reset ? '0 : arb_grant;
  assign req_ready = grant;
  assign gnt_any   = |grant;

  // One-hot grant selects the operands driven to the fpu; idle issues zeros.
  always_comb begin
    fpu_opA = '0;
    fpu_opB = '0;
    fpu_op  = ADD;
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        fpu_opA = req_opA[i*FP_WIDTH +: FP_WIDTH];
        fpu_opB = req_opB[i*FP_WIDTH +: FP_WIDTH];
        fpu_op  = req_op[i*OP_WIDTH +: OP_WIDTH];
        gnt_idx = IW'(i);
      end
    end
  end

  // Round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset)        last_grant <= IW'(NUM_REQ - 1);
    else if (gnt_any) last_grant <= gnt_idx;
  end

  // Tag pipe, shifts every cycle; idle slots carry id 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid <= '0;
      for (int unsigned s = 0; s < PIPELINE_DEPTH; s++) tag_id[s] <= '0;
    end else begin
      tag_valid[0] <= gnt_any;
      tag_id[0]    <= gnt_idx;
      for (int unsigned s = 1; s < PIPELINE_DEPTH; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_id[s]    <= tag_id[s-1];
      end
    end
  end

  // Per-requester in-flight counters.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (reset)                       out_cnt[i] <= '0;
      else if (grant[i] && !rsp_dec[i]) out_cnt[i] <= out_cnt[i] + CW'(1);
      else if (!grant[i] && rsp_dec[i]) out_cnt[i] <= out_cnt[i] - CW'(1);
    end
  end

  assign rsp_valid  = tag_valid[PIPELINE_DEPTH-1];
  assign rsp_id     = tag_id[PIPELINE_DEPTH-1];
  assign rsp_result = rsp_valid ? fpu_result : '0;
  assign busy       = |tag_valid;

`ifdef FPU_SCHED_FLAGS_EN
  assign rsp_flags = rsp_valid ? {fpu_inexact, fpu_underflow, fpu_overflow} : '0;
`else
  logic unused_flags;
  assign unused_flags = fpu_inexact ^ fpu_underflow ^ fpu_overflow;
  assign rsp_flags    = '0;
`endif

endmodule
